// File: rtl/noc_defs_pkg.sv
// Shared NoC definitions: flit width, default link credits and link FSM state encodings.
// Defaults for the width/depth macros apply only when the build does not supply them.
`ifndef PAYLOAD_SIZE
`define PAYLOAD_SIZE 8
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif
`ifndef FIFO_DEPTH
`define FIFO_DEPTH 4
`endif

package noc_defs_pkg;
  localparam int NOC_FLIT_W  = `PAYLOAD_SIZE + `ADDR_SZ;
  localparam int NOC_CREDITS = `FIFO_DEPTH;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    BLOCKED = 2'd2
  } link_state_e;
endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter saturating at MAX, with zero flag and a sticky error flag
// raised when a credit comes back while already full. Shared by link transmit and receive sides.
module credit_counter #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero,
  output logic         err
);
  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] count_reg;
  logic         err_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= MAX_C;
      err_reg   <= 1'b0;
    end else if (inc && !dec) begin
      if (count_reg == MAX_C) err_reg <= 1'b1;
      else                    count_reg <= count_reg + 1'b1;
    end else if (dec && !inc && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);
  assign err   = err_reg;
endmodule

// File: rtl/link_tx.sv
// Router output-port link transmitter: pops a FWFT flit FIFO under credit flow control and
// drives one registered flit per cycle. Optional statistics counters behind LINK_TX_STATS_EN.
module link_tx
  import noc_defs_pkg::*;
#(
  parameter int FLIT_W   = NOC_FLIT_W,
  parameter int CREDITS  = NOC_CREDITS,
  parameter int CREDIT_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic [FLIT_W-1:0]   fifo_item,
  output logic                fifo_read,
  output logic                link_valid,
  output logic [FLIT_W-1:0]   link_data,
  input  logic                link_credit,
  output logic [CREDIT_W-1:0] credits,
`ifdef LINK_TX_STATS_EN
  output logic [15:0]         tx_count,
  output logic [15:0]         stall_count,
`endif
  output logic                credit_err
);
  logic              fire;
  logic              credits_zero;
  logic              link_valid_reg;
  logic [FLIT_W-1:0] link_data_reg;
  link_state_e       state_reg, state_next;

  // Reset gating keeps the pop strobe quiet while the link is being reset.
  assign fire      = !reset && enable && !fifo_empty && !credits_zero;
  assign fifo_read = fire;

  credit_counter #(
    .MAX (CREDITS),
    .W   (CREDIT_W)
  ) u_credit (
    .clk   (clk),
    .reset (reset),
    .inc   (link_credit),
    .dec   (fire),
    .count (credits),
    .zero  (credits_zero),
    .err   (credit_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link_valid_reg <= 1'b0;
      link_data_reg  <= '0;
    end else begin
      link_valid_reg <= fire;
      if (fire) link_data_reg <= fifo_item;
    end
  end

  assign link_valid = link_valid_reg;
  assign link_data  = link_data_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Status only: transmission is decided by fire alone.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fire) state_next = ACTIVE;
      ACTIVE: begin
        if (fifo_empty || !enable) state_next = IDLE;
        else if (credits_zero)     state_next = BLOCKED;
      end
      BLOCKED: begin
        if (fire)            state_next = ACTIVE;
        else if (fifo_empty) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef LINK_TX_STATS_EN
  logic [15:0] tx_count_reg;
  logic [15:0] stall_count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_count_reg    <= '0;
      stall_count_reg <= '0;
    end else begin
      if (fire) tx_count_reg <= tx_count_reg + 1'b1;
      if (enable && !fifo_empty && credits_zero && stall_count_reg != 16'hFFFF)
        stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign tx_count    = tx_count_reg;
  assign stall_count = stall_count_reg;
`endif
endmodule

// File: tb/tb_link_tx.sv
// Directed, scoreboarded bench for link_tx: FIFO model, credit model and expected-flit queue.
// Build with LINK_TX_STATS_EN to also check the statistics counters.
module tb_link_tx;
  import noc_defs_pkg::*;

  localparam int FW = NOC_FLIT_W;
  localparam int CR = NOC_CREDITS;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          fifo_empty;
  logic [FW-1:0] fifo_item;
  logic          fifo_read;
  logic          link_valid;
  logic [FW-1:0] link_data;
  logic          link_credit;
  logic [2:0]    credits;
  logic          credit_err;
`ifdef LINK_TX_STATS_EN
  logic [15:0]   tx_count;
  logic [15:0]   stall_count;
  int            exp_tx;
  int            exp_stall;
`endif

  logic [FW-1:0] fifo_q[$];
  logic [FW-1:0] sb[$];
  int            exp_credits;
  logic          exp_err;
  int            tests = 0;
  int            fails = 0;

  link_tx dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_item   (fifo_item),
    .fifo_read   (fifo_read),
    .link_valid  (link_valid),
    .link_data   (link_data),
    .link_credit (link_credit),
    .credits     (credits),
`ifdef LINK_TX_STATS_EN
    .tx_count    (tx_count),
    .stall_count (stall_count),
`endif
    .credit_err  (credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_item  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic push(input logic [FW-1:0] v);
    fifo_q.push_back(v);
    drive_fifo();
  endtask

  task automatic model_reset();
    exp_credits = CR;
    exp_err     = 1'b0;
    sb.delete();
`ifdef LINK_TX_STATS_EN
    exp_tx    = 0;
    exp_stall = 0;
`endif
  endtask

  // One clock cycle: predict the pop, advance the models, then check the registered outputs.
  task automatic tick(input logic lc);
    logic fire_e;
    link_credit = lc;
    #1;
    fire_e = enable && (fifo_q.size() != 0) && (exp_credits != 0);
    chk("fifo_read", fifo_read, fire_e);
    if (fire_e) sb.push_back(fifo_q[0]);
`ifdef LINK_TX_STATS_EN
    if (fire_e) exp_tx = (exp_tx + 1) & 16'hFFFF;
    if (enable && fifo_q.size() != 0 && exp_credits == 0 && exp_stall != 16'hFFFF) exp_stall++;
`endif
    if (fire_e && !lc) exp_credits--;
    else if (!fire_e && lc) begin
      if (exp_credits == CR) exp_err = 1'b1;
      else                   exp_credits++;
    end
    @(posedge clk);
    #1;
    if (fire_e) void'(fifo_q.pop_front());
    drive_fifo();
    link_credit = 1'b0;
    chk("link_valid", link_valid, fire_e);
    if (fire_e) chk("link_data", link_data, sb.pop_front());
    chk("credits", credits, exp_credits);
    chk("credit_err", credit_err, exp_err);
`ifdef LINK_TX_STATS_EN
    chk("tx_count", tx_count, exp_tx);
    chk("stall_count", stall_count, exp_stall);
`endif
    $display("[TB] t=%0t pop=%0b link_valid=%0b data=0x%0h credits=%0d err=%0b", $time,
             fire_e, link_valid, link_data, credits, credit_err);
  endtask

  // Drain the FIFO and return every outstanding credit, with a bounded cycle budget.
  task automatic drain();
    for (int i = 0; i < 60 && (fifo_q.size() != 0 || exp_credits != CR); i++)
      tick(exp_credits != CR);
    chk("drain_done", {31'd0, (fifo_q.size() == 0 && exp_credits == CR)}, 32'd1);
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    link_credit = 1'b0;
    drive_fifo();
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_link_valid", link_valid, 0);
    chk("rst_link_data", link_data, 0);
    chk("rst_credits", credits, CR);
    chk("rst_credit_err", credit_err, 0);
    chk("rst_fifo_read", fifo_read, 0);
    chk("rst_state", dut.state_reg, IDLE);

    // 1: three flits, no credits returned
    push(12'h011); push(12'h022); push(12'h033);
    enable = 1'b1;
    tick(1'b0);
    chk("t1_state_active", dut.state_reg, ACTIVE);
    tick(1'b0); tick(1'b0); tick(1'b0);
    chk("t1_credits_1", credits, 1);
    drain();

    // 2: six flits, credits run out after four; one credit releases the fifth
    for (int i = 0; i < 6; i++) push(FW'(12'h100 + i));
    for (int i = 0; i < 6; i++) tick(1'b0);
    chk("t2_credits_0", credits, 0);
    chk("t2_state_blocked", dut.state_reg, BLOCKED);
    chk("t2_fifo_read_low", fifo_read, 0);
    tick(1'b1);
    tick(1'b0);
    chk("t2_fifo_left", fifo_q.size(), 1);
    drain();

    // 3: credit returned on every fire cycle keeps credits at the maximum
    for (int i = 0; i < 8; i++) push(FW'(12'h200 + 3 * i));
    for (int i = 0; i < 8; i++) tick(1'b1);
    tick(1'b0);
    chk("t3_credits_full", credits, CR);

    // 4: credit returned while full sets the sticky error
    tick(1'b1);
    tick(1'b0);
    tick(1'b0);
    chk("t4_err_sticky", credit_err, 1);

    // 5: enable dropped mid-stream for five cycles
    for (int i = 0; i < 6; i++) push(FW'(12'h300 + 7 * i));
    tick(1'b0); tick(1'b0);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b0);
    enable = 1'b1;
    drain();

    // 6: asynchronous reset with a flit on the link and two credits left
    for (int i = 0; i < 4; i++) push(FW'(12'h400 + i));
    tick(1'b0); tick(1'b0);
    chk("t6_credits_2", credits, 2);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_link_valid", link_valid, 0);
    chk("t6_rst_link_data", link_data, 0);
    chk("t6_rst_credits", credits, CR);
    chk("t6_rst_err", credit_err, 0);
    chk("t6_rst_fifo_read", fifo_read, 0);
`ifdef LINK_TX_STATS_EN
    chk("t6_rst_tx_count", tx_count, 0);
    chk("t6_rst_stall_count", stall_count, 0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
